// File: rtl/add_serial_pkg.sv
// add_serial shared types: FSM state, digit count and configuration check.
// Optional subtract support is enabled with ADD_SERIAL_SUB_EN.
package add_serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int n_digits(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic bit cfg_ok(input int width, input int digit);
      if (digit < 1 || digit > width) return 1'b0;
      return (width % digit) == 0;
   endfunction

endpackage

// File: rtl/add_serial_digit.sv
// add_digit: combinational DIGIT-bit ripple adder, exposes the carry into
// its top bit so the caller can form signed overflow.
module add_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co    = c[DIGIT];
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/add_serial.sv
// add_serial: digit-serial WIDTH-bit adder, DIGIT bits per clock, LSD first.
// Define ADD_SERIAL_SUB_EN to add the sub port (a - b - cin).
module add_serial
   import add_serial_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADD_SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N    = n_digits(WIDTH, DIGIT);
   localparam int CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (!cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
      $error("add_serial: WIDTH must be a multiple of DIGIT, DIGIT >= 1");
   end

   state_t           state;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic [WIDTH-1:0] a_nx, b_nx, sum_nx;
   logic [WIDTH-1:0] b_in;
   logic             c_in;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             cout_q, ovf_q;
   logic [DIGIT-1:0] d_s;
   logic             d_co, d_msb;

`ifdef ADD_SERIAL_SUB_EN
   assign b_in = sub ? ~b : b;
   assign c_in = sub ? ~cin : cin;
`else
   assign b_in = b;
   assign c_in = cin;
`endif

   add_digit #(
      .DIGIT(DIGIT)
   ) u_digit (
      .a    (a_q[DIGIT-1:0]),
      .b    (b_q[DIGIT-1:0]),
      .ci   (carry),
      .s    (d_s),
      .co   (d_co),
      .c_msb(d_msb)
   );

   // Single-digit build has nothing left to shift after one step.
   if (DIGIT == WIDTH) begin : g_one
      assign a_nx   = '0;
      assign b_nx   = '0;
      assign sum_nx = d_s;
   end else begin : g_multi
      assign a_nx   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
      assign b_nx   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
      assign sum_nx = {d_s, sum_q[WIDTH-1:DIGIT]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b_in;
                  carry <= c_in;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_q   <= a_nx;
               b_q   <= b_nx;
               sum_q <= sum_nx;
               carry <= d_co;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cout_q <= d_co;
                  ovf_q  <= d_msb ^ d_co;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_serial.sv
// Self-checking bench for add_serial: DIGIT=4, 16 and 1 instances
// checked against an arithmetic reference model.
module tb_add_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  in_valid = '0;
   logic [2:0]  out_ready = '0;
   logic [2:0]  in_ready, out_valid, cout, ovf;
   logic [15:0] a = '0, b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic [15:0] sum0, sum1, sum2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   add_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a), .b(b), .cin(cin),
`ifdef ADD_SERIAL_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .sum(sum0), .cout(cout[0]), .ovf(ovf[0]));

   add_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a), .b(b), .cin(cin),
`ifdef ADD_SERIAL_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .sum(sum1), .cout(cout[1]), .ovf(ovf[1]));

   add_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a), .b(b), .cin(cin),
`ifdef ADD_SERIAL_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .sum(sum2), .cout(cout[2]), .ovf(ovf[2]));

   function automatic logic [15:0] get_sum(input int k);
      if (k == 0) return sum0;
      if (k == 1) return sum1;
      return sum2;
   endfunction

   function automatic int lat_of(input int k);
      if (k == 0) return 4;
      if (k == 1) return 1;
      return 16;
   endfunction

   // Reference: plain integer arithmetic on the two's-complement operands.
   function automatic logic [17:0] model(input logic [15:0] x,
                                         input logic [15:0] y,
                                         input logic ci, input logic sb);
      logic [15:0] yy;
      logic        cc;
      logic [16:0] full;
      logic        o;
      yy   = sb ? ~y : y;
      cc   = sb ? ~ci : ci;
      full = {1'b0, x} + {1'b0, yy} + {16'd0, cc};
      o    = (x[15] == yy[15]) && (full[15] != x[15]);
      return {o, full[16], full[15:0]};
   endfunction

   task automatic do_op(input int k, input logic [15:0] x,
                        input logic [15:0] y, input logic ci,
                        input logic sb, input string tag);
      logic [17:0] exp_v;
      int lat;
      exp_v = model(x, y, ci, sb);
      @(negedge clk);
      a = x; b = y; cin = ci; sub = sb;
      in_valid[k] = 1'b1;
      out_ready[k] = 1'b1;
      checks++;
      if (in_ready[k] !== 1'b1) begin
         failures++;
         $display("FAIL %s in_ready before accept: got %b want 1", tag, in_ready[k]);
      end
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (out_valid[k] !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat != lat_of(k)) begin
         failures++;
         $display("FAIL %s latency: got %0d want %0d", tag, lat, lat_of(k));
      end
      checks++;
      if ({ovf[k], cout[k], get_sum(k)} !== exp_v) begin
         failures++;
         $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                  tag, get_sum(k), cout[k], ovf[k], exp_v[15:0], exp_v[16], exp_v[17]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
         failures++;
         $display("FAIL %s after transfer: got out_valid=%b in_ready=%b want 0 1",
                  tag, out_valid[k], in_ready[k]);
      end
      out_ready[k] = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 ||
             get_sum(k) !== 16'h0 || cout[k] !== 1'b0 || ovf[k] !== 1'b0) begin
            failures++;
            $display("FAIL %s inst%0d: got rdy=%b vld=%b sum=%h cout=%b ovf=%b want 1 0 0000 0 0",
                     tag, k, in_ready[k], out_valid[k], get_sum(k), cout[k], ovf[k]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset_state");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_idle("after_release");
   endtask

   task automatic test_directed();
      do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, "add_5555");
      do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap_ffff");
      do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf_7fff");
      do_op(0, 16'h00FF, 16'h0F00, 1'b1, 1'b0, "cin_one");
   endtask

   task automatic test_backpressure();
      logic [17:0] exp_v;
      int lat;
      exp_v = model(16'hABCD, 16'h1111, 1'b1, 1'b0);
      @(negedge clk);
      a = 16'hABCD; b = 16'h1111; cin = 1'b1; sub = 1'b0;
      in_valid[0] = 1'b1;
      out_ready[0] = 1'b0;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      lat = 0;
      while (out_valid[0] !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat != 4) begin
         failures++;
         $display("FAIL bp_latency: got %0d want 4", lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid[0] = ~in_valid[0];
         a = 16'($urandom);
         b = 16'($urandom);
         @(posedge clk);
         #1;
         checks++;
         if ({ovf[0], cout[0], sum0} !== exp_v || out_valid[0] !== 1'b1 ||
             in_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cycle %0d: got sum=%h cout=%b ovf=%b vld=%b rdy=%b want sum=%h cout=%b ovf=%b 1 0",
                     i, sum0, cout[0], ovf[0], out_valid[0], in_ready[0],
                     exp_v[15:0], exp_v[16], exp_v[17]);
         end
      end
      @(negedge clk);
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
         failures++;
         $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", in_ready[0], out_valid[0]);
      end
      do_op(0, 16'h0F0F, 16'h3003, 1'b0, 1'b0, "bp_next");
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
      in_valid[0] = 1'b1;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_idle("rst_mid_run");
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (i == 2) begin
            @(negedge clk);
            rst = 1'b0;
         end
         checks++;
         if (out_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_valid cycle %0d: got %b want 0", i, out_valid[0]);
         end
      end
      out_ready[0] = 1'b0;
      check_idle("rst_released");
      do_op(0, 16'h0100, 16'h0100, 1'b0, 1'b0, "post_rst");
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 12; i++) begin
            do_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0,
                  $sformatf("rand_i%0d_%0d", k, i));
         end
         do_op(k, 16'h8000, 16'h8000, 1'b0, 1'b0, $sformatf("neg_ovf_i%0d", k));
         do_op(k, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, $sformatf("all_ones_i%0d", k));
      end
   endtask

   task automatic test_back_to_back();
      int accepts;
      int cyc;
      int first_acc;
      int last_acc;
      @(negedge clk);
      a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0;
      in_valid[0] = 1'b1;
      out_ready[0] = 1'b1;
      accepts = 0;
      first_acc = -1;
      last_acc = -1;
      for (cyc = 0; cyc < 25; cyc++) begin
         @(posedge clk);
         if (in_ready[0] === 1'b1) begin
            accepts++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
         end
      end
      #1;
      in_valid[0] = 1'b0;
      checks++;
      if (accepts != 5 || (last_acc - first_acc) != 24) begin
         failures++;
         $display("FAIL b2b_throughput: got accepts=%0d span=%0d want 5 24",
                  accepts, last_acc - first_acc);
      end
      repeat (8) @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
   endtask

`ifdef ADD_SERIAL_SUB_EN
   task automatic test_sub();
      for (int k = 0; k < 3; k++) begin
         do_op(k, 16'h0005, 16'h0007, 1'b0, 1'b1, $sformatf("sub_5m7_i%0d", k));
         do_op(k, 16'h8000, 16'h0001, 1'b0, 1'b1, $sformatf("sub_ovf_i%0d", k));
         for (int i = 0; i < 6; i++) begin
            do_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  $sformatf("sub_rand_i%0d_%0d", k, i));
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
`ifdef ADD_SERIAL_SUB_EN
      test_sub();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
